// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: BCD count/adjust datapath with pause, clear and rollover pulse.
// Optional adjust-field blinking is enabled by defining STOPWATCH_BLINK_EN.
module stopwatch_core (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       one_hz_tick,
  input  logic       two_hz_tick,
  input  logic       blink_tick,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank_mask,
  output logic       paused,
  output logic       rollover
);

  logic [3:0] minTens_q, minOnes_q, secTens_q, secOnes_q;
  logic [3:0] minTens_d, minOnes_d, secTens_d, secOnes_d;
  logic       paused_q, paused_d;
  logic       rollover_q, rollover_d;
  logic [8:0] secInc, minInc;

  // Advance a two-digit 00..59 field; returns {wrapped, tens, ones}.
  // Out-of-range inputs are folded onto the wrap path so digits stay legal.
  function automatic logic [8:0] incField(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] tensN;
    logic [3:0] onesN;
    logic       wrap;
    wrap  = 1'b0;
    tensN = tens;
    onesN = ones + 4'd1;
    if (ones >= 4'd9) begin
      onesN = 4'd0;
      if (tens >= 4'd5) begin
        tensN = 4'd0;
        wrap  = 1'b1;
      end else begin
        tensN = tens + 4'd1;
      end
    end
    return {wrap, tensN, onesN};
  endfunction

  always_comb begin
    secInc    = incField(secTens_q, secOnes_q);
    minInc    = incField(minTens_q, minOnes_q);
    minTens_d = minTens_q;
    minOnes_d = minOnes_q;
    secTens_d = secTens_q;
    secOnes_d = secOnes_q;
    rollover_d = 1'b0;
    paused_d   = paused_q ^ pause_pulse;

    // Increment decisions use the pre-toggle pause state; clear beats any tick.
    if (clr_pulse) begin
      minTens_d = 4'd0;
      minOnes_d = 4'd0;
      secTens_d = 4'd0;
      secOnes_d = 4'd0;
    end else if (!paused_q) begin
      if (!adj && one_hz_tick) begin
        {secTens_d, secOnes_d} = secInc[7:0];
        if (secInc[8]) begin
          {minTens_d, minOnes_d} = minInc[7:0];
          rollover_d = minInc[8];
        end
      end else if (adj && two_hz_tick) begin
        if (sel) begin
          {secTens_d, secOnes_d} = secInc[7:0];
        end else begin
          {minTens_d, minOnes_d} = minInc[7:0];
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      minTens_q  <= 4'd0;
      minOnes_q  <= 4'd0;
      secTens_q  <= 4'd0;
      secOnes_q  <= 4'd0;
      paused_q   <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      minTens_q  <= minTens_d;
      minOnes_q  <= minOnes_d;
      secTens_q  <= secTens_d;
      secOnes_q  <= secOnes_d;
      paused_q   <= paused_d;
      rollover_q <= rollover_d;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic       phase_q, phase_d;
  logic [3:0] blankMask_q, blankMask_d;

  // Mask is computed from the next phase so it lines up with the phase register.
  always_comb begin
    phase_d     = adj ? (phase_q ^ blink_tick) : 1'b0;
    blankMask_d = 4'b0000;
    if (adj && phase_d) begin
      blankMask_d = sel ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      phase_q     <= 1'b0;
      blankMask_q <= 4'b0000;
    end else begin
      phase_q     <= phase_d;
      blankMask_q <= blankMask_d;
    end
  end

  assign blank_mask = blankMask_q;
`else
  logic unusedBlink;
  assign unusedBlink = blink_tick;
  assign blank_mask  = 4'b0000;
`endif

  assign min_tens = minTens_q;
  assign min_ones = minOnes_q;
  assign sec_tens = secTens_q;
  assign sec_ones = secOnes_q;
  assign paused   = paused_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus random traffic against
// a seconds-count reference model. Honours STOPWATCH_BLINK_EN like the design.
module tb_stopwatch_core;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       one_hz_tick = 1'b0, two_hz_tick = 1'b0, blink_tick = 1'b0;
  logic       pause_pulse = 1'b0, clr_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank_mask;
  logic       paused, rollover;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: elapsed time as a plain 0..3599 seconds count.
  int         modelTime = 0;
  logic       modelPaused = 1'b0;
  logic       modelRoll = 1'b0;
  logic       modelPhase = 1'b0;
  logic [3:0] modelMask = 4'b0000;
  int         rollCount = 0;

`ifdef STOPWATCH_BLINK_EN
  localparam logic [3:0] MaskMin = 4'b1100;
`else
  localparam logic [3:0] MaskMin = 4'b0000;
`endif

  stopwatch_core dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .one_hz_tick(one_hz_tick),
    .two_hz_tick(two_hz_tick),
    .blink_tick (blink_tick),
    .pause_pulse(pause_pulse),
    .clr_pulse  (clr_pulse),
    .adj        (adj),
    .sel        (sel),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .blank_mask (blank_mask),
    .paused     (paused),
    .rollover   (rollover)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] timeDigits(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput();
    logic [15:0] dutDigits;
    dutDigits = {min_tens, min_ones, sec_tens, sec_ones};
    assertCount++;
    assert (dutDigits === timeDigits(modelTime)) else begin
      failCount++;
      $error("[TB] FAIL digits: got %h expected %h", dutDigits, timeDigits(modelTime));
    end
    assertCount++;
    assert (paused === modelPaused) else begin
      failCount++;
      $error("[TB] FAIL paused: got %b expected %b", paused, modelPaused);
    end
    assertCount++;
    assert (rollover === modelRoll) else begin
      failCount++;
      $error("[TB] FAIL rollover: got %b expected %b", rollover, modelRoll);
    end
    assertCount++;
    assert (blank_mask === modelMask) else begin
      failCount++;
      $error("[TB] FAIL blank_mask: got %b expected %b", blank_mask, modelMask);
    end
  endtask

  task automatic checkTime(input string tag, input int mm, input int ss, input logic expPaused);
    logic [15:0] dutDigits;
    logic [15:0] expDigits;
    dutDigits = {min_tens, min_ones, sec_tens, sec_ones};
    expDigits = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    assertCount++;
    assert (dutDigits === expDigits && paused === expPaused) else begin
      failCount++;
      $error("[TB] FAIL %s: got %h paused=%b expected %h paused=%b",
             tag, dutDigits, paused, expDigits, expPaused);
    end
  endtask

  task automatic checkMask(input string tag, input logic [3:0] expMask);
    assertCount++;
    assert (blank_mask === expMask) else begin
      failCount++;
      $error("[TB] FAIL %s: got %b expected %b", tag, blank_mask, expMask);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic applyStimulus(input logic r, input logic oh, input logic th, input logic bt,
                               input logic pp, input logic cp, input logic a, input logic s);
    rst = r; one_hz_tick = oh; two_hz_tick = th; blink_tick = bt;
    pause_pulse = pp; clr_pulse = cp; adj = a; sel = s;
    @(posedge sys_clk);
    #1;
    if (r) begin
      modelTime = 0; modelPaused = 1'b0; modelRoll = 1'b0; modelPhase = 1'b0;
    end else begin
      modelRoll = 1'b0;
      if (cp) begin
        modelTime = 0;
      end else if (!modelPaused) begin
        if (!a && oh) begin
          modelRoll = (modelTime == 3599);
          modelTime = (modelTime + 1) % 3600;
        end else if (a && th) begin
          if (s) modelTime = (modelTime / 60) * 60 + (modelTime % 60 + 1) % 60;
          else   modelTime = ((modelTime / 60 + 1) % 60) * 60 + modelTime % 60;
        end
      end
      if (pp) modelPaused = !modelPaused;
      modelPhase = a ? (modelPhase ^ bt) : 1'b0;
    end
`ifdef STOPWATCH_BLINK_EN
    modelMask = (!r && a && modelPhase) ? (s ? 4'b0011 : 4'b1100) : 4'b0000;
`else
    modelMask = 4'b0000;
`endif
    if (rollover === 1'b1) rollCount++;
    rst = 1'b0; one_hz_tick = 1'b0; two_hz_tick = 1'b0; blink_tick = 1'b0;
    pause_pulse = 1'b0; clr_pulse = 1'b0;
    checkOutput();
  endtask

  task automatic countTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i % 7 == 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic adjustTicks(input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, s);
    end
  endtask

  initial begin
    logic randAdj;
    randAdj = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkTime("reset", 0, 0, 1'b0);
    checkMask("reset_mask", 4'b0000);

    // 61 seconds of counting, no rollover expected
    rollCount = 0;
    countTicks(61);
    checkTime("count61", 1, 1, 1'b0);
    assertCount++;
    assert (rollCount == 0) else begin
      failCount++;
      $error("[TB] FAIL count61_roll: got %0d expected 0", rollCount);
    end

    // Preload 59:59 via adjust, then one count tick wraps to 00:00
    adjustTicks(1'b0, 58);
    adjustTicks(1'b1, 58);
    checkTime("preload", 59, 59, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkTime("wrap", 0, 0, 1'b0);
    assertCount++;
    assert (rollover === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL wrap_roll: got %b expected 1", rollover);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    assertCount++;
    assert (rollover === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL wrap_roll_end: got %b expected 0", rollover);
    end

    // Pause on the same edge as a tick uses the pre-toggle state
    countTicks(5);
    checkTime("run5", 0, 5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkTime("pause_tick", 0, 6, 1'b1);
    countTicks(10);
    checkTime("paused_hold", 0, 6, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Seconds-field adjust does not carry; count tick ignored; minutes wrap
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adjustTicks(1'b0, 12);
    adjustTicks(1'b1, 58);
    checkTime("at1258", 12, 58, 1'b0);
    adjustTicks(1'b1, 2);
    checkTime("sec_nocarry", 12, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkTime("adj_ignore1hz", 12, 0, 1'b0);
    adjustTicks(1'b0, 48);
    checkTime("min_wrap", 0, 0, 1'b0);

    // Clear beats a tick and leaves pause alone; reset discards a tick
    adjustTicks(1'b0, 34);
    adjustTicks(1'b1, 27);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkTime("at3427", 34, 27, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkTime("clr_tick", 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    countTicks(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkTime("rst_tick", 0, 0, 1'b0);

    // Blink phase behaviour
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkMask("blink_on", MaskMin);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkMask("blink_off", 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMask("blink_exit", 4'b0000);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) randAdj = !randAdj;
      applyStimulus(($urandom_range(0, 127) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 47) == 0),
                    randAdj,
                    1'($urandom_range(0, 1)));
    end

    // Long count run to exercise wraps through the model
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (paused === 1'b1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    adjustTicks(1'b0, 59);
    adjustTicks(1'b1, 50);
    countTicks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
